// File: rtl/lab_frame_stats.sv
// Per-frame mean/variance accumulator for the l, alpha and beta channels (signed 3.13 in).
// Sums and sums-of-squares are gathered over 2^LOG2_N pixels, then one shared squarer finishes each channel.
module lab_frame_stats #(
  parameter int LOG2_N = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_valid,
  input  logic [15:0] i_l,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_mean_l,
  output logic [15:0] o_mean_a,
  output logic [15:0] o_mean_b,
  output logic [15:0] o_var_l,
  output logic [15:0] o_var_a,
  output logic [15:0] o_var_b
);

  localparam int SW = 16 + LOG2_N;
  localparam int QW = 31 + LOG2_N;

  typedef enum logic [1:0] {IDLE, ACCUM, CALC, DONE} state_t;

  state_t              state;
  logic [LOG2_N-1:0]   cnt;
  logic [1:0]          k;
  logic [SW-1:0]       sum_l, sum_a, sum_b;
  logic [QW-1:0]       sq_l, sq_a, sq_b;

  logic [15:0]         mean_c;
  logic [30:0]         ex2_c;
  logic signed [31:0]  mean_ext;
  logic [31:0]         mean_sq;
  logic [15:0]         var_c;

  function automatic logic [SW-1:0] sext(input logic [15:0] x);
    return {{LOG2_N{x[15]}}, x};
  endfunction

  // The square of a 3.13 value is a non-negative 6.26 value, at most 2^30.
  function automatic logic [QW-1:0] square(input logic [15:0] x);
    logic signed [31:0] xs;
    xs = {{16{x[15]}}, x};
    return QW'(xs * xs);
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    mean_c = sum_l[SW-1 -: 16];
    ex2_c  = sq_l[QW-1 -: 31];
    case (k)
      2'd1: begin
        mean_c = sum_a[SW-1 -: 16];
        ex2_c  = sq_a[QW-1 -: 31];
      end
      2'd2: begin
        mean_c = sum_b[SW-1 -: 16];
        ex2_c  = sq_b[QW-1 -: 31];
      end
      default: ;
    endcase
  end

  // Top bits of the sum are the floor-divided mean; floor rounding can push ex2 below mean^2.
  assign mean_ext = {{16{mean_c[15]}}, mean_c};
  assign mean_sq  = mean_ext * mean_ext;
  assign var_c    = ({1'b0, ex2_c} < mean_sq) ? 16'h0000
                                              : 16'(({1'b0, ex2_c} - mean_sq) >> 15);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      k        <= '0;
      sum_l    <= '0;
      sum_a    <= '0;
      sum_b    <= '0;
      sq_l     <= '0;
      sq_a     <= '0;
      sq_b     <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_mean_l <= '0;
      o_mean_a <= '0;
      o_mean_b <= '0;
      o_var_l  <= '0;
      o_var_a  <= '0;
      o_var_b  <= '0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        state  <= ACCUM;
        cnt    <= '0;
        k      <= '0;
        sum_l  <= '0;
        sum_a  <= '0;
        sum_b  <= '0;
        sq_l   <= '0;
        sq_a   <= '0;
        sq_b   <= '0;
        o_busy <= 1'b1;
      end else begin
        case (state)
          ACCUM: begin
            if (i_valid) begin
              sum_l <= sum_l + sext(i_l);
              sum_a <= sum_a + sext(i_a);
              sum_b <= sum_b + sext(i_b);
              sq_l  <= sq_l + square(i_l);
              sq_a  <= sq_a + square(i_a);
              sq_b  <= sq_b + square(i_b);
              cnt   <= cnt + 1'b1;
              if (cnt == '1) state <= CALC;
            end
          end
          CALC: begin
            case (k)
              2'd0: begin
                o_mean_l <= mean_c;
                o_var_l  <= var_c;
              end
              2'd1: begin
                o_mean_a <= mean_c;
                o_var_a  <= var_c;
              end
              default: begin
                o_mean_b <= mean_c;
                o_var_b  <= var_c;
              end
            endcase
            if (k == 2'd2) begin
              k      <= '0;
              state  <= DONE;
              o_busy <= 1'b0;
            end else begin
              k <= k + 2'd1;
            end
          end
          DONE: begin
            o_done <= 1'b1;
            state  <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lab_frame_stats.sv
// Directed-sequence bench for lab_frame_stats with LOG2_N = 2, randomized pixel data and gaps.
// Expected statistics come from plain integer arithmetic over each frame's pixel list.
module tb_lab_frame_stats;

  localparam int LOG2_N = 2;
  localparam int N      = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] l = '0, a = '0, b = '0;
  logic        busy, done;
  logic [15:0] mean_l, mean_a, mean_b, var_l, var_a, var_b;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] fl [N];
  logic [15:0] fa [N];
  logic [15:0] fb [N];
  logic [15:0] exp_mean [3];
  logic [15:0] exp_var  [3];

  lab_frame_stats #(.LOG2_N(LOG2_N)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_valid  (valid),
    .i_l      (l),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_mean_l (mean_l),
    .o_mean_a (mean_a),
    .o_mean_b (mean_b),
    .o_var_l  (var_l),
    .o_var_a  (var_a),
    .o_var_b  (var_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Mean = floor(sum / N); variance = floor(E[x^2]) - mean^2 clamped at 0, shown as 5.11.
  function automatic void ref_stats(input logic [15:0] px [N],
                                    output logic [15:0] m, output logic [15:0] v);
    longint s = 0;
    longint q = 0;
    longint x, mm, ex2, d;
    for (int i = 0; i < N; i++) begin
      x = longint'($signed(px[i]));
      s += x;
      q += x * x;
    end
    mm  = (s - ((s % N + N) % N)) / N;
    ex2 = q / N;
    d   = ex2 - mm * mm;
    if (d < 0) d = 0;
    d = d / 32768;
    m = mm[15:0];
    v = d[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      fl[i] = 16'($urandom);
      fa[i] = 16'($urandom);
      fb[i] = 16'($urandom);
    end
  endtask

  task automatic pulse_start(input bit tie);
    start = 1'b1;
    valid = tie;
    l = 16'($urandom);
    a = 16'($urandom);
    b = 16'($urandom);
    tick();
    start = 1'b0;
    valid = 1'b0;
  endtask

  task automatic send_pixels(input int n, input int max_gap);
    int g;
    for (int i = 0; i < n; i++) begin
      g = int'($urandom_range(max_gap, 0));
      repeat (g) begin
        valid = 1'b0;
        l = 16'($urandom);
        a = 16'($urandom);
        b = 16'($urandom);
        tick();
      end
      valid = 1'b1;
      l = fl[i];
      a = fa[i];
      b = fb[i];
      tick();
    end
    valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " mean_l"}, 32'(mean_l), 32'(exp_mean[0]));
    check({tag, " mean_a"}, 32'(mean_a), 32'(exp_mean[1]));
    check({tag, " mean_b"}, 32'(mean_b), 32'(exp_mean[2]));
    check({tag, " var_l"},  32'(var_l),  32'(exp_var[0]));
    check({tag, " var_a"},  32'(var_a),  32'(exp_var[1]));
    check({tag, " var_b"},  32'(var_b),  32'(exp_var[2]));
  endtask

  // Called just after the edge that samples the last pixel; o_done must rise on the fourth edge.
  task automatic finish_frame(input string tag);
    int lat = 0;
    ref_stats(fl, exp_mean[0], exp_var[0]);
    ref_stats(fa, exp_mean[1], exp_var[1]);
    ref_stats(fb, exp_mean[2], exp_var[2]);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) check({tag, " busy_calc"}, 32'(busy), 32'd1);
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    check({tag, " done_latency"}, 32'(lat), 32'd4);
    check({tag, " busy_done"}, 32'(busy), 32'd0);
    check_outputs(tag);
    tick();
    check({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones;

    // Reset state
    repeat (2) tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    exp_mean = '{16'h0, 16'h0, 16'h0};
    exp_var  = '{16'h0, 16'h0, 16'h0};
    check_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Constant frame
    fl = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
    fa = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    fb = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    pulse_start(1'b0);
    check("start busy", 32'(busy), 32'd1);
    send_pixels(N, 0);
    finish_frame("const");
    check("const mean_l lit", 32'(mean_l), 32'h2000);
    check("const var_l lit", 32'(var_l), 32'h0000);

    // Alternating a, extreme b, random l
    fill_random();
    fa = '{16'h2000, 16'hE000, 16'h2000, 16'hE000};
    fb = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    pulse_start(1'b0);
    send_pixels(N, 0);
    finish_frame("alt_ext");
    check("alt mean_a lit", 32'(mean_a), 32'h0000);
    check("alt var_a lit", 32'(var_a), 32'h0800);
    check("ext mean_b lit", 32'(mean_b), 32'h8000);
    check("ext var_b lit", 32'(var_b), 32'h0000);

    // IDLE valid pulses are ignored, then random frames with gaps
    for (int f = 0; f < 6; f++) begin
      repeat (3) begin
        valid = 1'b1;
        l = 16'($urandom);
        a = 16'($urandom);
        b = 16'($urandom);
        tick();
      end
      valid = 1'b0;
      check("idle ignored", 32'(mean_l), 32'(exp_mean[0]));
      fill_random();
      pulse_start(1'b0);
      send_pixels(N, (f == 0) ? 0 : 3);
      finish_frame($sformatf("rand%0d", f));
    end

    // Restart after two pixels
    fill_random();
    pulse_start(1'b0);
    send_pixels(2, 1);
    fill_random();
    pulse_start(1'b0);
    send_pixels(N, 2);
    finish_frame("restart");

    // Start and valid on the same edge: that pixel is dropped
    fill_random();
    pulse_start(1'b1);
    send_pixels(N, 1);
    finish_frame("tie");

    // Start during CALC: l already written, a/b untouched, no done
    fill_random();
    pulse_start(1'b0);
    send_pixels(N, 0);
    tick();
    pulse_start(1'b0);
    ref_stats(fl, exp_mean[0], exp_var[0]);
    check("abort busy", 32'(busy), 32'd1);
    check_outputs("abort");
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    check("abort no_done", 32'(dones), 32'd0);
    fill_random();
    send_pixels(N, 2);
    finish_frame("post_abort");

    // Asynchronous reset in the middle of ACCUM
    fill_random();
    pulse_start(1'b0);
    send_pixels(2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_mean = '{16'h0, 16'h0, 16'h0};
    exp_var  = '{16'h0, 16'h0, 16'h0};
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check_outputs("midrst");
    rst_n = 1'b1;
    tick();
    fill_random();
    send_pixels(N, 0);
    check("midrst idle", 32'(busy), 32'd0);
    check("midrst idle mean_l", 32'(mean_l), 32'h0000);
    fill_random();
    pulse_start(1'b0);
    send_pixels(N, 3);
    finish_frame("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
